// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencing controller for CP0: accept, drain, then one atomic commit.
// Optional internal COUNT/COMPARE timer on IP7 when EXC_TIMER_EN is defined.
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_irq,
    input  logic [1:0]  sw_ip,
    input  logic [7:0]  im,
    input  logic        ie,
    input  logic        exl,
    input  logic        erl,
    input  logic        bev,
    input  logic        sys_req,
    input  logic        brk_req,
    input  logic [31:0] req_pc,
    input  logic        eret,
    input  logic        pipe_ack,
    input  logic        cnt_wr,
    input  logic        cmp_wr,
    input  logic [31:0] wr_data,
    output logic        exc_ack,
    output logic        busy,
    output logic        flush_req,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        epc_wr,
    output logic        cause_wr,
    output logic        exl_set,
    output logic [31:0] epc_data,
    output logic [4:0]  exc_code,
    output logic [7:0]  ip_out,
    output logic [31:0] count,
    output logic [31:0] compare
);
    localparam logic [31:0] EXCEPTION_ENTRY = 32'h8000_0180;
    localparam logic [31:0] BOOT_ENTRY      = 32'hBFC0_0380;
    localparam logic [4:0]  CODE_INT = 5'd0, CODE_SYS = 5'd8, CODE_BP = 5'd9;

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        timer_ip;
    logic        irq_take;
    logic [4:0]  code_nxt;

    assign ip_out   = {hw_irq[5] | timer_ip, hw_irq[4:0], sw_ip};
    assign irq_take = ie & ~exl & ~erl & ~eret & (|(ip_out & im));
    assign code_nxt = sys_req ? CODE_SYS : (brk_req ? CODE_BP : CODE_INT);

    // Pulses are suppressed while rst is high so a reset never acks or commits.
    always_comb begin
        state_nxt = state;
        exc_ack   = 1'b0;
        flush_req = 1'b0;
        redirect  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (sys_req || brk_req || irq_take)) begin
                    exc_ack   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                flush_req = 1'b1;
                if (pipe_ack) state_nxt = COMMIT;
            end
            COMMIT: begin
                redirect  = ~rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign epc_wr      = redirect;
    assign cause_wr    = redirect;
    assign exl_set     = redirect;
    assign redirect_pc = (redirect && bev) ? BOOT_ENTRY : EXCEPTION_ENTRY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            epc_data <= 32'd0;
            exc_code <= CODE_INT;
        end else begin
            state <= state_nxt;
            if (exc_ack) begin
                epc_data <= req_pc;
                exc_code <= code_nxt;
            end
        end
    end

`ifdef EXC_TIMER_EN
    // Match raises timer_ip one cycle later; a COMPARE write wins over a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 32'd0;
            compare  <= 32'hFFFF_FFFF;
            timer_ip <= 1'b0;
        end else begin
            count <= cnt_wr ? wr_data : count + 32'd1;
            if (cmp_wr) begin
                compare  <= wr_data;
                timer_ip <= 1'b0;
            end else if (count == compare) begin
                timer_ip <= 1'b1;
            end
        end
    end
`else
    logic unused_timer;
    assign unused_timer = ^{cnt_wr, cmp_wr, wr_data};
    assign count    = 32'd0;
    assign compare  = 32'd0;
    assign timer_ip = 1'b0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, corner sequences, random vs model.
module tb_exc_ctrl;
    localparam logic [31:0] EXC  = 32'h8000_0180;
    localparam logic [31:0] BOOT = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_irq;
    logic [1:0]  sw_ip;
    logic [7:0]  im;
    logic        ie, exl, erl, bev, sys_req, brk_req, eret, pipe_ack, cnt_wr, cmp_wr;
    logic [31:0] req_pc, wr_data;
    logic        exc_ack, busy, flush_req, redirect, epc_wr, cause_wr, exl_set;
    logic [31:0] redirect_pc, epc_data, count, compare;
    logic [4:0]  exc_code;
    logic [7:0]  ip_out;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .hw_irq(hw_irq), .sw_ip(sw_ip), .im(im), .ie(ie), .exl(exl),
        .erl(erl), .bev(bev), .sys_req(sys_req), .brk_req(brk_req), .req_pc(req_pc),
        .eret(eret), .pipe_ack(pipe_ack), .cnt_wr(cnt_wr), .cmp_wr(cmp_wr), .wr_data(wr_data),
        .exc_ack(exc_ack), .busy(busy), .flush_req(flush_req), .redirect(redirect),
        .redirect_pc(redirect_pc), .epc_wr(epc_wr), .cause_wr(cause_wr), .exl_set(exl_set),
        .epc_data(epc_data), .exc_code(exc_code), .ip_out(ip_out), .count(count),
        .compare(compare)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack, busy, flush, redir, epcw, causew, exls;
        logic [31:0] rpc, epc;
        logic [4:0]  code;
        logic [7:0]  ip;
        logic [31:0] cnt, cmp;
    } obs_t;

    typedef struct {
        logic        sys, brk;
        logic [5:0]  hw;
        logic [7:0]  im;
        logic        ie, exl, eret, bev, pack;
        logic [31:0] pc;
        logic        ack, busy, flush, redir;
        logic [31:0] rpc, epc;
        logic [4:0]  code;
        logic [7:0]  ip;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: an accepted event is "in flight" until the drain completes,
    // then produces exactly one commit cycle.
    bit          m_inflight, m_commit, m_tip;
    logic [31:0] m_epc, m_cnt, m_cmp;
    logic [4:0]  m_code;

    function automatic obs_t model_out();
        obs_t o;
        logic [7:0] ip;
        bit irq, idle;
        ip     = {hw_irq[5] | m_tip, hw_irq[4:0], sw_ip};
        irq    = ie && !exl && !erl && !eret && ((ip & im) != 8'd0);
        idle   = !m_inflight && !m_commit;
        o.ack  = idle && !rst && (sys_req || brk_req || irq);
        o.busy = !idle;
        o.flush = m_inflight;
        o.redir = m_commit && !rst;
        o.epcw = o.redir; o.causew = o.redir; o.exls = o.redir;
        o.rpc  = (o.redir && bev) ? BOOT : EXC;
        o.epc  = m_epc;
        o.code = m_code;
        o.ip   = ip;
        o.cnt  = m_cnt;
        o.cmp  = m_cmp;
        return o;
    endfunction

    task automatic model_update();
        obs_t o;
        o = model_out();
        if (rst) begin
            m_inflight = 0; m_commit = 0; m_epc = 0; m_code = 0;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_inflight) begin
            if (pipe_ack) begin m_inflight = 0; m_commit = 1; end
        end else if (o.ack) begin
            m_inflight = 1;
            m_epc  = req_pc;
            m_code = sys_req ? 5'd8 : (brk_req ? 5'd9 : 5'd0);
        end
`ifdef EXC_TIMER_EN
        if (rst) begin
            m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_tip = 0;
        end else begin
            if (cmp_wr) m_tip = 0;
            else if (m_cnt == m_cmp) m_tip = 1;
            if (cmp_wr) m_cmp = wr_data;
            m_cnt = cnt_wr ? wr_data : m_cnt + 32'd1;
        end
`else
        m_cnt = 0; m_cmp = 0; m_tip = 0;
`endif
    endtask

    function automatic obs_t sample();
        return '{exc_ack, busy, flush_req, redirect, epc_wr, cause_wr, exl_set,
                 redirect_pc, epc_data, exc_code, ip_out, count, compare};
    endfunction

    task automatic compare_obs(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic settle_check(input string name);
        #2;
        compare_obs(name, model_out());
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        sys_req = 0; brk_req = 0; hw_irq = 0; sw_ip = 0; im = 0; ie = 0; exl = 0; erl = 0;
        bev = 0; eret = 0; pipe_ack = 0; cnt_wr = 0; cmp_wr = 0; wr_data = 0; req_pc = 0;
    endtask

    vec_t tbl[16];

    initial begin
        obs_t e;
        //          sys brk hw     im     ie exl er bev pk pc            ack bsy fl rd rpc   epc           code  ip
        tbl[0]  = '{0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, EXC,  32'h0,        5'd0, 8'h00};
        tbl[1]  = '{1, 0, 6'h00, 8'h00, 1, 0, 0, 0, 0, 32'h00400024,  1, 0, 0, 0, EXC,  32'h0,        5'd0, 8'h00};
        tbl[2]  = '{0, 0, 6'h00, 8'h00, 1, 0, 0, 0, 1, 32'h00400028,  0, 1, 1, 0, EXC,  32'h00400024, 5'd8, 8'h00};
        tbl[3]  = '{0, 0, 6'h00, 8'h00, 1, 0, 0, 0, 0, 32'h00400028,  0, 1, 0, 1, EXC,  32'h00400024, 5'd8, 8'h00};
        tbl[4]  = '{0, 0, 6'h00, 8'h00, 1, 1, 0, 0, 0, 32'h80000180,  0, 0, 0, 0, EXC,  32'h00400024, 5'd8, 8'h00};
        tbl[5]  = '{1, 1, 6'h01, 8'hFF, 1, 0, 0, 0, 0, 32'h00400100,  1, 0, 0, 0, EXC,  32'h00400024, 5'd8, 8'h04};
        tbl[6]  = '{1, 1, 6'h01, 8'hFF, 1, 0, 0, 0, 1, 32'h00400100,  0, 1, 1, 0, EXC,  32'h00400100, 5'd8, 8'h04};
        tbl[7]  = '{1, 1, 6'h01, 8'hFF, 1, 0, 0, 0, 1, 32'h00400100,  0, 1, 0, 1, EXC,  32'h00400100, 5'd8, 8'h04};
        tbl[8]  = '{0, 0, 6'h01, 8'hFF, 1, 1, 0, 0, 0, 32'h80000180,  0, 0, 0, 0, EXC,  32'h00400100, 5'd8, 8'h04};
        tbl[9]  = '{0, 0, 6'h04, 8'hEF, 1, 0, 0, 0, 0, 32'h00400200,  0, 0, 0, 0, EXC,  32'h00400100, 5'd8, 8'h10};
        tbl[10] = '{0, 0, 6'h04, 8'hFF, 1, 1, 0, 0, 0, 32'h00400200,  0, 0, 0, 0, EXC,  32'h00400100, 5'd8, 8'h10};
        tbl[11] = '{0, 0, 6'h04, 8'hFF, 1, 0, 1, 0, 0, 32'h00400200,  0, 0, 0, 0, EXC,  32'h00400100, 5'd8, 8'h10};
        tbl[12] = '{0, 0, 6'h04, 8'hFF, 1, 0, 0, 1, 0, 32'h00400200,  1, 0, 0, 0, EXC,  32'h00400100, 5'd8, 8'h10};
        tbl[13] = '{0, 0, 6'h00, 8'hFF, 1, 0, 0, 1, 1, 32'h00400204,  0, 1, 1, 0, EXC,  32'h00400200, 5'd0, 8'h00};
        tbl[14] = '{0, 0, 6'h00, 8'hFF, 1, 0, 0, 1, 0, 32'h00400204,  0, 1, 0, 1, BOOT, 32'h00400200, 5'd0, 8'h00};
        tbl[15] = '{0, 0, 6'h00, 8'hFF, 1, 1, 0, 1, 0, 32'hBFC00380,  0, 0, 0, 0, EXC,  32'h00400200, 5'd0, 8'h00};

        // Reset, with an interrupt pending to prove nothing is acked meanwhile.
        idle_inputs();
        rst = 1; ie = 1; im = 8'hFF; hw_irq = 6'h3F; sys_req = 1;
        m_inflight = 0; m_commit = 0; m_epc = 0; m_code = 0; m_cnt = 0; m_cmp = 0; m_tip = 0;
        adv(); adv();
        #2;
        e = '{0, 0, 0, 0, 0, 0, 0, EXC, 32'h0, 5'd0, 8'hFC, m_cnt, m_cmp};
        compare_obs("reset_state", e);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        adv();

        for (int i = 0; i < 16; i++) begin
            sys_req = tbl[i].sys; brk_req = tbl[i].brk; hw_irq = tbl[i].hw; im = tbl[i].im;
            ie = tbl[i].ie; exl = tbl[i].exl; eret = tbl[i].eret; bev = tbl[i].bev;
            pipe_ack = tbl[i].pack; req_pc = tbl[i].pc;
            #2;
            e = model_out();
            e.ack = tbl[i].ack; e.busy = tbl[i].busy; e.flush = tbl[i].flush;
            e.redir = tbl[i].redir; e.epcw = tbl[i].redir; e.causew = tbl[i].redir;
            e.exls = tbl[i].redir; e.rpc = tbl[i].rpc; e.epc = tbl[i].epc;
            e.code = tbl[i].code; e.ip = tbl[i].ip;
            compare_obs($sformatf("vec%0d", i), e);
            adv();
        end

        // Drain held off for 10 cycles.
        idle_inputs();
        brk_req = 1; req_pc = 32'h00400300;
        settle_check("drain_accept");
        chk("drain_ack", {31'd0, exc_ack}, 32'd1);
        adv();
        brk_req = 0;
        for (int i = 0; i < 10; i++) begin
            settle_check("drain_hold");
            chk("drain_flush", {31'd0, flush_req}, 32'd1);
            chk("drain_noredir", {31'd0, redirect}, 32'd0);
            adv();
        end
        pipe_ack = 1;
        settle_check("drain_ack_in");
        adv();
        pipe_ack = 0;
        settle_check("drain_commit");
        chk("drain_redirect", {31'd0, redirect}, 32'd1);
        chk("drain_code", {27'd0, exc_code}, 32'd9);
        chk("drain_epc", epc_data, 32'h00400300);
        adv();

        // Reset while draining abandons the sequence.
        sys_req = 1; req_pc = 32'h00400400;
        settle_check("rst_accept");
        adv();
        sys_req = 0;
        settle_check("rst_drain");
        adv();
        rst = 1; pipe_ack = 1;
        settle_check("rst_cycle");
        adv();
        rst = 0;
        settle_check("rst_after");
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_epcwr", {31'd0, epc_wr}, 32'd0);
        chk("rst_epcdata", epc_data, 32'd0);
        adv();
        pipe_ack = 0;
        settle_check("rst_after2");
        chk("rst_noredir", {31'd0, redirect}, 32'd0);
        adv();

        // Timer wrap and compare match.
        idle_inputs();
        cnt_wr = 1; wr_data = 32'hFFFF_FFFE;
        settle_check("tmr_cntwr");
        adv();
        cnt_wr = 0; cmp_wr = 1; wr_data = 32'h1;
        settle_check("tmr_cmpwr");
        adv();
        cmp_wr = 0;
`ifdef EXC_TIMER_EN
        settle_check("tmr_ff");
        chk("tmr_count_ff", count, 32'hFFFF_FFFF);
        chk("tmr_compare", compare, 32'h1);
        adv();
        settle_check("tmr_wrap");
        chk("tmr_count_0", count, 32'h0);
        adv();
        settle_check("tmr_match");
        chk("tmr_count_1", count, 32'h1);
        chk("tmr_ip_pre", {31'd0, ip_out[7]}, 32'd0);
        adv();
        settle_check("tmr_set");
        chk("tmr_ip_set", {31'd0, ip_out[7]}, 32'd1);
        adv();
        cmp_wr = 1; wr_data = 32'h100;
        settle_check("tmr_sticky");
        chk("tmr_ip_sticky", {31'd0, ip_out[7]}, 32'd1);
        adv();
        cmp_wr = 0;
        settle_check("tmr_clr");
        chk("tmr_ip_clr", {31'd0, ip_out[7]}, 32'd0);
        adv();
`else
        settle_check("tmr_off");
        chk("tmr_count_off", count, 32'd0);
        chk("tmr_compare_off", compare, 32'd0);
        chk("tmr_ip_off", {31'd0, ip_out[7]}, 32'd0);
        adv();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(199) == 0);
            sys_req  = ($urandom_range(7) == 0);
            brk_req  = ($urandom_range(7) == 0);
            hw_irq   = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
            sw_ip    = ($urandom_range(7) == 0) ? 2'($urandom) : 2'd0;
            im       = 8'($urandom);
            ie       = ($urandom_range(3) != 0);
            exl      = ($urandom_range(3) == 0);
            erl      = ($urandom_range(7) == 0);
            eret     = ($urandom_range(7) == 0);
            bev      = 1'($urandom);
            pipe_ack = ($urandom_range(2) == 0);
            req_pc   = $urandom;
            cnt_wr   = ($urandom_range(49) == 0);
            cmp_wr   = ($urandom_range(49) == 0);
            wr_data  = ($urandom_range(1) == 0) ? m_cnt + 32'($urandom_range(6)) : $urandom;
            settle_check($sformatf("rand%0d", i));
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
